pm32_mac: RTL and testbench

Signed multiply-accumulate sequencer for the 32x32 serial multiplier. Accepts a stream of signed operand pairs over a valid/ready handshake and issues each pair to the multiplier with a one-cycle start pulse. It sign-extends every 64-bit product into a wide accumulator and emits the dot-product result, with term count and sticky overflow flag, when the pair tagged `last` completes. It sits directly upstream of the multiplier (drives it) and directly downstream of it (consumes its product).

---
 rtl/pm32_mac.sv | 152 +++++++++++++++
 tb/tb_pm32_mac.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm32_mac.sv
// pm32_mac: signed multiply-accumulate sequencer wrapped around a serial
// 32x32 multiplier. Takes operand pairs one at a time, issues each to the
// multiplier with a single-cycle start pulse, sign-extends every 64-bit
// product into a wide accumulator, and presents the dot-product (with term
// count and sticky overflow) once the pair tagged last has been folded in.
module pm32_mac #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_last,
   output logic             mul_start,
   output logic [31:0]      mul_mc,
   output logic [31:0]      mul_mp,
   input  logic [63:0]      mul_p,
   input  logic             mul_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. Ready is a registered state decode and never looks at valid;
   // the sender keeps valid and data steady until the transfer edge.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic             last_q, last_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             mul_start_q, mul_start_d;
   logic             out_valid_q, out_valid_d;

   logic             in_fire;
   logic             out_fire;
   logic             done_fire;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum;
   logic             add_ovf;

   // mul_done is only trusted in WAIT: outside it the multiplier may still be
   // holding the previous product with done high.
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid_q & out_ready;
   assign done_fire = (state_q == S_WAIT) & mul_done;

   // Two's-complement add: overflow when both addends share a sign and the
   // wrapped sum does not.
   assign prod_ext = ACC_W'($signed(mul_p));
   assign sum      = acc_q + prod_ext;
   assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);

   // Next-state, operand capture, accumulation and registered-output decode
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      last_d   = last_q;
      acc_d    = acc_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               a_d     = in_a;
               b_d     = in_b;
               last_d  = in_last;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_fire) begin
               acc_d   = sum;
               count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
               ovf_d   = ovf_q | add_ovf;
               state_d = last_q ? S_OUT : S_IDLE;
            end
         end
         S_OUT: begin
            if (out_fire) begin
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE);
      mul_start_d = (state_d == S_ISSUE);
      out_valid_d = (state_d == S_OUT);
   end

   // State, datapath and handshake outputs; reset may arrive in any state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         mul_start_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         mul_start_q <= mul_start_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mul_start = mul_start_q;
   assign out_valid = out_valid_q;
   assign mul_mc    = a_q;
   assign mul_mp    = b_q;
   assign out_acc   = acc_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pm32_mac.sv
// tb_pm32_mac: drives two pm32_mac instances (72-bit and 64-bit accumulators)
// from one stimulus stream and one serial-multiplier model, and checks them
// every cycle against a transaction-level reference of the dot product.
module tb_pm32_mac;

   localparam logic signed [73:0] MAX72 = (74'sd1 <<< 71) - 74'sd1;
   localparam logic signed [73:0] MIN72 = -(74'sd1 <<< 71);
   localparam logic signed [65:0] MAX64 = (66'sd1 <<< 63) - 66'sd1;
   localparam logic signed [65:0] MIN64 = -(66'sd1 <<< 63);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_last, out_ready, mul_done;
   logic [31:0] in_a, in_b;
   logic [63:0] mul_p;
   logic        in_ready, mul_start, out_valid;
   logic [31:0] mul_mc, mul_mp;
   logic [71:0] out_acc;
   logic [7:0]  out_count;
   logic        out_ovf;
   logic        in_ready64, mul_start64, out_valid64;
   logic [31:0] mul_mc64, mul_mp64;
   logic [63:0] out_acc64;
   logic [7:0]  out_count64;
   logic        out_ovf64;

   pm32_mac #(.ACC_W(72), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start),
      .mul_mc(mul_mc), .mul_mp(mul_mp), .mul_p(mul_p), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   pm32_mac #(.ACC_W(64), .CNT_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start64),
      .mul_mc(mul_mc64), .mul_mp(mul_mp64), .mul_p(mul_p), .mul_done(mul_done),
      .out_valid(out_valid64), .out_ready(out_ready), .out_acc(out_acc64),
      .out_count(out_count64), .out_ovf(out_ovf64)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout at %0t", name, $time);
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
      longint r;
      r = longint'($signed(a)) * longint'($signed(b));
      return r;
   endfunction

   function automatic logic [71:0] add72(input logic [71:0] acc, input logic [63:0] p);
      logic [71:0] r;
      r = $signed(acc) + $signed(p);
      return r;
   endfunction

   function automatic bit ovf72(input logic [71:0] acc, input logic [63:0] p);
      logic signed [73:0] ex;
      ex = $signed(acc) + $signed(p);
      return (ex > MAX72) || (ex < MIN72);
   endfunction

   function automatic bit ovf64(input logic [63:0] acc, input logic [63:0] p);
      logic signed [65:0] ex;
      ex = $signed(acc) + $signed(p);
      return (ex > MAX64) || (ex < MIN64);
   endfunction

   // ---------------- serial multiplier model ----------------
   int          lat_lo = 1;
   int          lat_hi = 6;
   int          lat;
   bit          mbusy;
   logic [31:0] c_mc, c_mp;
   int          n_starts = 0;
   int          n_hs = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbusy    <= 1'b0;
         lat      <= 0;
         mul_done <= 1'b1;
         mul_p    <= 64'hDEAD_BEEF_0BAD_F00D;
      end else if (mul_start) begin
         n_starts <= n_starts + 1;
         mbusy    <= 1'b1;
         lat      <= $urandom_range(lat_hi, lat_lo);
         c_mc     <= mul_mc;
         c_mp     <= mul_mp;
         mul_done <= 1'b0;
         mul_p    <= {$urandom, $urandom};
      end else if (mbusy) begin
         if (lat == 0) begin
            chk("mc_held", mul_mc, c_mc);
            mbusy    <= 1'b0;
            mul_done <= 1'b1;
            mul_p    <= prod(c_mc, c_mp);
         end else begin
            lat <= lat - 1;
         end
      end
   end

   // ---------------- transaction-level reference ----------------
   bit          m_busy, m_start, m_res, m_last;
   logic [31:0] m_a, m_b;
   logic [71:0] m_acc72;
   logic [63:0] m_acc64;
   bit          m_ovf72, m_ovf64;
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_start <= 1'b0;
         m_res   <= 1'b0;
         m_acc72 <= '0;
         m_acc64 <= '0;
         m_ovf72 <= 1'b0;
         m_ovf64 <= 1'b0;
         m_cnt   <= 0;
      end else if (m_start) begin
         m_start <= 1'b0;
      end else if (m_busy) begin
         if (mul_done) begin
            m_busy  <= 1'b0;
            m_acc72 <= add72(m_acc72, prod(m_a, m_b));
            m_acc64 <= m_acc64 + prod(m_a, m_b);
            m_ovf72 <= m_ovf72 | ovf72(m_acc72, prod(m_a, m_b));
            m_ovf64 <= m_ovf64 | ovf64(m_acc64, prod(m_a, m_b));
            m_cnt   <= m_cnt + 1;
            if (m_last) m_res <= 1'b1;
         end
      end else if (m_res) begin
         if (out_ready) begin
            m_res   <= 1'b0;
            m_acc72 <= '0;
            m_acc64 <= '0;
            m_ovf72 <= 1'b0;
            m_ovf64 <= 1'b0;
            m_cnt   <= 0;
         end
      end else if (in_valid) begin
         m_busy  <= 1'b1;
         m_start <= 1'b1;
         m_a     <= in_a;
         m_b     <= in_b;
         m_last  <= in_last;
         n_hs    <= n_hs + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, !(m_busy || m_res));
         chk("in_ready64", in_ready64, !(m_busy || m_res));
         chk("mul_start", mul_start, m_start);
         chk("mul_start64", mul_start64, m_start);
         chk("out_valid", out_valid, m_res);
         chk("out_valid64", out_valid64, m_res);
         if (m_start) begin
            chk("mul_mc", mul_mc, m_a);
            chk("mul_mp", mul_mp, m_b);
         end
         if (m_res) begin
            chk("out_acc", out_acc, m_acc72);
            chk("out_acc64", out_acc64, m_acc64);
            chk("out_count", out_count, (m_cnt > 255) ? 255 : m_cnt);
            chk("out_count64", out_count64, (m_cnt > 255) ? 255 : m_cnt);
            chk("out_ovf", out_ovf, m_ovf72);
            chk("out_ovf64", out_ovf64, m_ovf64);
         end
      end
   end

   // ---------------- driver tasks ----------------
   bit rnd = 1'b0;

   task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
      int n = 0;
      while ((m_busy || m_res) && n < 2000) begin
         in_valid = $urandom_range(1, 0);
         in_a     = $urandom;
         in_b     = $urandom;
         in_last  = $urandom_range(1, 0);
         if (rnd) out_ready = $urandom_range(1, 0);
         @(negedge clk);
         n++;
      end
      if (m_busy || m_res) timeout_fail("send");
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input logic [71:0] e72, input logic [63:0] e64, input int ecnt,
                          input bit eo72, input bit eo64, input int hold);
      int n = 0;
      while (!m_res && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!m_res) begin
         timeout_fail("collect");
         return;
      end
      chk("lit_acc72", out_acc, e72);
      chk("lit_acc64", out_acc64, e64);
      chk("lit_count", out_count, ecnt);
      chk("lit_ovf72", out_ovf, eo72);
      chk("lit_ovf64", out_ovf64, eo64);
      chk("model_acc72", m_acc72, e72);
      chk("model_acc64", m_acc64, e64);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic chk_reset_values();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_mul_start", mul_start, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_acc", out_acc, 72'd0);
      chk("rst_out_count", out_count, 8'd0);
      chk("rst_out_ovf", out_ovf, 1'b0);
      chk("rst_mul_mc", mul_mc, 32'd0);
      chk("rst_out_acc64", out_acc64, 64'd0);
      chk("rst_in_ready64", in_ready64, 1'b1);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] ext [4];
      ext[0] = 32'h8000_0000;
      ext[1] = 32'h7FFF_FFFF;
      ext[2] = 32'h0000_0000;
      ext[3] = 32'hFFFF_FFFF;
      if ($urandom_range(3, 0) == 0) return ext[$urandom_range(3, 0)];
      return $urandom;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_values();
      #2 rst_n = 1'b1;
      @(negedge clk);

      // single term 3 * -5
      send(32'd3, -32'sd5, 1'b1);
      collect(72'hFF_FFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, 1, 1'b0, 1'b0, 0);
      chk("one_start_pulse", n_starts, 1);

      // four-term vector
      send(32'd2, 32'd3, 1'b0);
      send(-32'sd4, 32'd5, 1'b0);
      send(32'd7, -32'sd1, 1'b0);
      send(32'd100, 32'd100, 1'b1);
      collect(72'd9979, 64'd9979, 4, 1'b0, 1'b0, 0);

      // two (-2^31)^2 terms, held 20 cycles under back-pressure
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      send(32'h8000_0000, 32'h8000_0000, 1'b1);
      collect(72'h00_8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2, 1'b0, 1'b1, 20);
      send(32'd1, 32'd1, 1'b1);
      collect(72'd1, 64'd1, 1, 1'b0, 1'b0, 0);

      // asynchronous reset in the middle of a multiply
      lat_lo = 10;
      lat_hi = 12;
      send(32'd9, 32'd9, 1'b0);
      send(32'd5, 32'd5, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_values();
      @(negedge clk);
      #2 rst_n = 1'b1;
      lat_lo = 1;
      lat_hi = 6;
      @(negedge clk);
      send(32'd6, 32'd7, 1'b1);
      collect(72'd42, 64'd42, 1, 1'b0, 1'b0, 0);

      // term counter saturation
      lat_lo = 0;
      lat_hi = 1;
      for (int i = 0; i < 260; i++) send(32'd1, 32'd1, i == 259);
      collect(72'd260, 64'd260, 255, 1'b0, 1'b0, 0);

      // random vectors with random back-pressure and in_valid noise
      lat_lo = 0;
      lat_hi = 8;
      rnd = 1'b1;
      for (int v = 0; v < 40; v++) begin
         int len;
         len = $urandom_range(6, 1);
         for (int t = 0; t < len; t++) send(pick(), pick(), t == len - 1);
      end
      begin
         int n = 0;
         out_ready = 1'b1;
         while ((m_busy || m_res) && n < 2000) begin
            @(negedge clk);
            n++;
         end
         if (m_busy || m_res) timeout_fail("drain");
         out_ready = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("start_per_handshake", n_starts, n_hs);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
